ipsxe_floating_point_adder_arbiter_v1_0: RTL and testbench
==========================================================

// Module: ipsxe_floating_point_adder_arbiter_v1_0
// PURPOSE
//  Shares one pipelined FMA adder stage among N_REQ requesters. Round-robin issue of at most one op per
//  clock-enabled cycle; a requester-ID tag travels alongside the adder pipe; results go into a credit-protected
//  result FIFO with valid/ready back-pressure. Sits between the multiplier front-ends and the normaliser.
// PARAMETERS
//  N_REQ        4   number of requesters (2..8)
//  W_OP         77  operand bundle width per requester {a_mul_b, sign_c, exp_c, man_c, c_is_0}
//  W_RES        59  adder result width (o_add_out of the adder)
//  ADD_LATENCY  4   adder register stages enabled by LATENCY_CONFIG (1..8)
//  FIFO_DEPTH   8   result FIFO entries, power of 2, >= ADD_LATENCY
// PORTS
//  i_clk        in   1                clock
//  i_rst        in   1                reset, asynchronous, active-high
//  i_aclken     in   1                clock enable shared with the adder
//  i_req_valid  in   N_REQ            per-requester op valid
//  i_req_op     in   N_REQ*W_OP       per-requester operands, slot i at [i*W_OP +: W_OP]
//  o_req_ready  out  N_REQ            one-hot accept, combinational
//  o_add_op     out  W_OP             operands to the adder input, combinational mux of the granted slot
//  o_add_valid  out  1                an op is issued this cycle
//  i_add_result in   W_RES            adder output
//  o_res_valid  out  1                result FIFO head valid
//  i_res_ready  in   1                downstream accepts the head
//  o_res_data   out  W_RES            result
//  o_res_id     out  $clog2(N_REQ)    requester index of the result
//  o_busy       out  1                in-flight != 0 or FIFO not empty
// BEHAVIOUR
//  Reset (async, i_rst=1): tag pipe invalid, in-flight=0, FIFO empty, RR pointer=0.
//   o_res_valid=0, o_busy=0, o_req_ready=0, o_add_valid=0.
//  Issue condition: i_aclken & |i_req_valid & (fifo_count + inflight < FIFO_DEPTH).
//  Grant: first valid slot at or after the RR pointer, wrapping N_REQ-1 -> 0.
//   On issue the pointer becomes grant+1 mod N_REQ; otherwise it holds.
//  o_req_ready[g] = o_add_valid = issue; a transfer is valid&ready. o_add_op = i_req_op[g]; zero when not issuing.
//  Tag pipe: ADD_LATENCY stages of {valid, id}. Stage 0 loads {issue, g}.
//   The pipe shifts only when i_aclken=1, in lock-step with the adder; when i_aclken=0 all state holds.
//  Push: on the edge where i_aclken=1 and the last tag stage is valid, push {i_add_result, id} into the FIFO.
//  Pop: o_res_valid & i_res_ready, independent of i_aclken.
//  Latency: with i_aclken held high, an issue in cycle T gives o_res_valid with that result in cycle
//   T+ADD_LATENCY+1 if the FIFO was empty.
//  Ordering: results leave in issue order.
//  In-flight counter: +1 on issue, -1 on push, unchanged on both or neither. Range 0..ADD_LATENCY.
//  Credit rule: no issue when fifo_count + inflight = FIFO_DEPTH, so a push can never overflow.
//   Push and pop in the same cycle while the FIFO is full is legal; the count is unchanged.
//  Empty FIFO: o_res_data and o_res_id hold their last value, o_res_valid=0.
//   A push into an empty FIFO is not bypassed to the output.
//  A reset asserted mid-operation discards every in-flight and buffered result with no output.
//  An undriven or unused slot has its valid tied 0 and is never granted.
// CONFIGURATION
//  IPSXE_FP_ADD_ARB_PERF_CNT_EN defined: adds outputs o_issue_cnt[31:0] and o_stall_cnt[31:0].
//   o_issue_cnt increments on each issue.
//   o_stall_cnt increments on cycles with i_aclken & |i_req_valid & ~issue.
//   Both wrap at 2^32 and reset to 0.
//  Not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Only req 2 valid, 1 op, aclken=1, ready=1 -> o_req_ready=4'b0100 in cycle T.
//     o_res_valid in T+5 (ADD_LATENCY=4) with o_res_id=2 and o_res_data equal to the adder model.
//  2. All 4 requesters valid continuously, i_res_ready=1 -> grants 0,1,2,3,0,1... one per cycle.
//     Results carry ids in the same order.
//  3. i_res_ready=0, all valid -> exactly 8 issues, then o_req_ready=0.
//     The FIFO fills to 8 with no overflow; raising ready drains 8 results in order and issuing resumes.
//  4. Issue at T, i_aclken=0 for cycles T+1..T+3 -> tag pipe and RR pointer frozen.
//     The result appears 3 cycles later than in test 1, exactly once.
//  5. Assert i_rst for 1 cycle with 3 ops in flight and 2 in the FIFO -> o_res_valid=0 and o_busy=0 at once.
//     No stale result appears afterwards.
//  6. With IPSXE_FP_ADD_ARB_PERF_CNT_EN, run test 3 for 20 cycles -> o_issue_cnt=8, o_stall_cnt=12.

Source files
------------

// File: rtl/ipsxe_floating_point_adder_arbiter_v1_0.sv
// Round-robin arbiter sharing one pipelined FMA adder among N_REQ requesters.
// Define IPSXE_FP_ADD_ARB_PERF_CNT_EN to add the issue/stall counter outputs.
module ipsxe_floating_point_adder_arbiter_v1_0 #(
    parameter int N_REQ       = 4,
    parameter int W_OP        = 77,
    parameter int W_RES       = 59,
    parameter int ADD_LATENCY = 4,
    parameter int FIFO_DEPTH  = 8,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_aclken,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*W_OP-1:0]   i_req_op,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [W_OP-1:0]         o_add_op,
    output logic                    o_add_valid,
    input  logic [W_RES-1:0]        i_add_result,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic [W_RES-1:0]        o_res_data,
    output logic [ID_W-1:0]         o_res_id,
    output logic                    o_busy
`ifdef IPSXE_FP_ADD_ARB_PERF_CNT_EN
    ,
    output logic [31:0]             o_issue_cnt,
    output logic [31:0]             o_stall_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [W_OP-1:0]        ops [N_REQ];
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        grant;
    logic                   found;
    logic                   issue;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          fifo_count;
    logic [CW:0]            credit_used;
    logic [ADD_LATENCY-1:0] tag_v;
    logic [ID_W-1:0]        tag_id [ADD_LATENCY];
    logic                   push;
    logic                   pop;
    logic [W_RES-1:0]       mem_d [FIFO_DEPTH];
    logic [ID_W-1:0]        mem_id [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [W_RES-1:0]       last_d;
    logic [ID_W-1:0]        last_id;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        assign ops[i] = i_req_op[i*W_OP +: W_OP];
    end

    // First valid slot at or after the round-robin pointer
    always_comb begin
        int j;
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && i_req_valid[ID_W'(j)]) begin
                found = 1'b1;
                grant = ID_W'(j);
            end
        end
    end

    assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(inflight);
    assign issue = ~i_rst & i_aclken & found
                 & (credit_used < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        o_req_ready = '0;
        if (issue) o_req_ready[grant] = 1'b1;
    end

    assign o_add_valid = issue;
    assign o_add_op    = issue ? ops[grant] : '0;

    assign push        = i_aclken & tag_v[ADD_LATENCY-1];
    assign o_res_valid = (fifo_count != '0);
    assign pop         = o_res_valid & i_res_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Tag pipe advances in lock-step with the adder's clock enable
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag_v <= '0;
            for (int i = 0; i < ADD_LATENCY; i++) tag_id[i] <= '0;
        end else if (i_aclken) begin
            tag_v[0]  <= issue;
            tag_id[0] <= grant;
            for (int i = 1; i < ADD_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inflight <= '0;
        end else begin
            unique case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_d     <= '0;
            last_id    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                last_d  <= mem_d[rd_ptr];
                last_id <= mem_id[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_d[wr_ptr]  <= i_add_result;
            mem_id[wr_ptr] <= tag_id[ADD_LATENCY-1];
        end
    end

    // Outputs hold the last popped entry while the FIFO is empty
    assign o_res_data = o_res_valid ? mem_d[rd_ptr] : last_d;
    assign o_res_id   = o_res_valid ? mem_id[rd_ptr] : last_id;
    assign o_busy     = (inflight != '0) | o_res_valid;

`ifdef IPSXE_FP_ADD_ARB_PERF_CNT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_issue_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (issue) o_issue_cnt <= o_issue_cnt + 32'd1;
            if (i_aclken & (|i_req_valid) & ~issue)
                o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ipsxe_floating_point_adder_arbiter_v1_0.sv
// Bench for the adder arbiter: directed scenarios plus a random phase,
// checked against a queue-based model of issue, latency and result order.
module tb_ipsxe_floating_point_adder_arbiter_v1_0;

    localparam int N_REQ       = 4;
    localparam int W_OP        = 77;
    localparam int W_RES       = 59;
    localparam int ADD_LATENCY = 4;
    localparam int FIFO_DEPTH  = 8;
    localparam int ID_W        = 2;

    logic                  clk;
    logic                  rst;
    logic                  aclken;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*W_OP-1:0] req_op;
    logic [N_REQ-1:0]      req_ready;
    logic [W_OP-1:0]       add_op;
    logic                  add_valid;
    logic [W_RES-1:0]      add_result;
    logic                  res_valid;
    logic                  res_ready;
    logic [W_RES-1:0]      res_data;
    logic [ID_W-1:0]       res_id;
    logic                  busy;
`ifdef IPSXE_FP_ADD_ARB_PERF_CNT_EN
    logic [31:0]           issue_cnt;
    logic [31:0]           stall_cnt;
`endif

    logic [W_OP-1:0]  ops [N_REQ];
    logic [W_RES-1:0] apipe [ADD_LATENCY];

    ipsxe_floating_point_adder_arbiter_v1_0 #(
        .N_REQ(N_REQ), .W_OP(W_OP), .W_RES(W_RES),
        .ADD_LATENCY(ADD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_aclken(aclken),
        .i_req_valid(req_valid),
        .i_req_op(req_op),
        .o_req_ready(req_ready),
        .o_add_op(add_op),
        .o_add_valid(add_valid),
        .i_add_result(add_result),
        .o_res_valid(res_valid),
        .i_res_ready(res_ready),
        .o_res_data(res_data),
        .o_res_id(res_id),
        .o_busy(busy)
`ifdef IPSXE_FP_ADD_ARB_PERF_CNT_EN
        ,
        .o_issue_cnt(issue_cnt),
        .o_stall_cnt(stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        req_op = '0;
        for (int i = 0; i < N_REQ; i++) req_op[i*W_OP +: W_OP] = ops[i];
    end

    function automatic logic [W_RES-1:0] add_model(input logic [W_OP-1:0] op);
        return op[W_RES-1:0] ^ W_RES'(op >> 18);
    endfunction

    // Adder stand-in: ADD_LATENCY enabled stages
    always @(posedge clk) begin
        if (aclken) begin
            apipe[0] <= add_model(add_op);
            for (int i = 1; i < ADD_LATENCY; i++) apipe[i] <= apipe[i-1];
        end
    end
    assign add_result = apipe[ADD_LATENCY-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: ops in the adder with remaining enabled edges, then result queue
    int               rr_m;
    int               fl_id [$];
    logic [W_RES-1:0] fl_d [$];
    int               fl_c [$];
    int               fq_id [$];
    logic [W_RES-1:0] fq_d [$];
    int               last_id;
    logic [W_RES-1:0] last_d;
    bit               have_last;
    int               obs_issue;
    int               obs_pop;

    task automatic model_clear();
        fl_id.delete(); fl_d.delete(); fl_c.delete();
        fq_id.delete(); fq_d.delete();
        rr_m = 0;
        have_last = 0;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N_REQ; i++)
            ops[i] = W_OP'({$urandom, $urandom, $urandom});
    endtask

    task automatic tick();
        int g, s, outst;
        bit iss;
        logic [N_REQ-1:0] er;
        logic [W_OP-1:0] eop;
        #1;
        outst = fl_id.size() + fq_id.size();
        g = -1;
        for (int k = 0; k < N_REQ; k++) begin
            s = (rr_m + k) % N_REQ;
            if (g < 0 && req_valid[s]) g = s;
        end
        iss = aclken && (g >= 0) && (outst < FIFO_DEPTH);
        er = '0;
        eop = '0;
        if (iss) begin
            er[g] = 1'b1;
            eop = ops[g];
        end
        chk("req_ready", req_ready, er);
        chk("add_valid", add_valid, iss);
        chk("add_op", add_op, eop);
        chk("res_valid", res_valid, fq_id.size() != 0);
        if (fq_id.size() != 0) begin
            chk("res_id", res_id, fq_id[0]);
            chk("res_data", res_data, fq_d[0]);
        end else if (have_last) begin
            chk("hold_id", res_id, last_id);
            chk("hold_data", res_data, last_d);
        end
        chk("busy", busy, outst != 0);
        if (add_valid) obs_issue++;
        if (res_valid && res_ready) obs_pop++;
        if (fq_id.size() != 0 && res_ready) begin
            last_id = fq_id.pop_front();
            last_d  = fq_d.pop_front();
            have_last = 1;
        end
        if (aclken) begin
            foreach (fl_c[i]) fl_c[i]--;
            while (fl_c.size() != 0 && fl_c[0] == 0) begin
                fq_id.push_back(fl_id.pop_front());
                fq_d.push_back(fl_d.pop_front());
                void'(fl_c.pop_front());
            end
        end
        if (iss) begin
            fl_id.push_back(g);
            fl_d.push_back(add_model(ops[g]));
            fl_c.push_back(ADD_LATENCY);
            rr_m = (g + 1) % N_REQ;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_add_valid", add_valid, 1'b0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n, base;
        rst = 1'b1;
        aclken = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        obs_issue = 0;
        obs_pop = 0;
        rand_ops();
        model_clear();
        @(negedge clk);
        do_reset();

        // single op from requester 2
        rand_ops();
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
        chk("t1_latency", n, ADD_LATENCY);
        chk("t1_id", res_id, 2);
        tick();

        // all requesters valid: rotating grants from slot 3
        req_valid = '1;
        for (int i = 0; i < 24; i++) begin
            rand_ops();
            #1;
            chk("t2_grant", req_ready, 4'b0001 << ((3 + i) % 4));
            tick();
        end
        req_valid = '0;
        for (int i = 0; i < 10; i++) tick();

        // back-pressure: credits stop issue at FIFO_DEPTH
        do_reset();
        res_ready = 1'b0;
        req_valid = '1;
        base = obs_issue;
        for (int i = 0; i < 20; i++) begin rand_ops(); tick(); end
        chk("t3_issues", obs_issue - base, FIFO_DEPTH);
        #1;
        chk("t3_ready_low", req_ready, '0);
`ifdef IPSXE_FP_ADD_ARB_PERF_CNT_EN
        chk("t6_issue_cnt", issue_cnt, 32'd8);
        chk("t6_stall_cnt", stall_cnt, 32'd12);
`endif
        req_valid = '0;
        res_ready = 1'b1;
        base = obs_pop;
        for (int i = 0; i < 12; i++) tick();
        chk("t3_drained", obs_pop - base, FIFO_DEPTH);
        req_valid = '1;
        base = obs_issue;
        for (int i = 0; i < 4; i++) begin rand_ops(); tick(); end
        chk("t3_resume", obs_issue - base, 4);
        req_valid = '0;
        for (int i = 0; i < 10; i++) tick();

        // clock-enable freeze for three cycles after issue
        rand_ops();
        req_valid = 4'b0001;
        tick();
        req_valid = '1;
        aclken = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        req_valid = '0;
        aclken = 1'b1;
        n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
        chk("t4_latency", n + 3, ADD_LATENCY + 3);
        chk("t4_id", res_id, 0);
        tick();
        req_valid = '1;
        #1;
        chk("t4_rr", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        for (int i = 0; i < 10; i++) tick();

        // reset with 3 in flight and 2 buffered
        res_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin rand_ops(); tick(); end
        req_valid = '0;
        tick();
        chk("t5_pre_valid", res_valid, 1'b1);
        chk("t5_pre_busy", busy, 1'b1);
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            req_valid = N_REQ'($urandom);
            res_ready = ($urandom % 4) != 0;
            aclken = ($urandom % 5) != 0;
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        aclken = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("final_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
